// File: rtl/uart_rx.sv
// uart_rx: UART receiver with selectable 7/8 data bits, optional
// odd/even/mark/space parity and 1/2 stop bits. Bit timing comes from an
// external generator: uart_enable starts it and clk_uart returns a bit-rate
// square wave whose rising edges mark the bit centres.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   rx              serial line (idle high, asynchronous to clk)
//   clk_uart        bit clock from the generator
//   uart_enable     generator enable, high whenever not idle
//   data_size       0 = 7 data bits, 1 = 8 data bits
//   parity_en       a parity bit follows the data
//   parity_mode     11 odd, 10 even, 01 mark, 00 space
//   stop_bit_size   0 = 1 stop bit, 1 = 2 stop bits
//   data            last received character (data[7] = 0 in 7-bit mode)
//   valid           one-cycle strobe when data and error flags update
//   parity_error    parity mismatch in the last frame
//   frame_error     a stop bit of the last frame was sampled low
//   ready           high only while idle
module uart_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       clk_uart,
  output logic       uart_enable,
  input  logic       data_size,
  input  logic       parity_en,
  input  logic [1:0] parity_mode,
  input  logic       stop_bit_size,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       ready
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic rx_meta_q, rx_s_q, rx_prev_q, clk_uart_prev_q;
  logic rx_fall, uart_tick, last_data_bit;

  logic       cfg_size_q, cfg_size_d;
  logic       cfg_par_en_q, cfg_par_en_d;
  logic [1:0] cfg_par_mode_q, cfg_par_mode_d;
  logic       cfg_stop_q, cfg_stop_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       par_err_acc_q, par_err_acc_d;
  logic       frm_err_acc_q, frm_err_acc_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       parity_error_q, parity_error_d;
  logic       frame_error_q, frame_error_d;

  // Two-stage synchronizer on rx plus a delayed copy for falling-edge
  // detection. Resetting to 1 matches an idle line, so leaving reset never
  // looks like a start bit. clk_uart is delayed once for its rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      rx_prev_q       <= 1'b1;
      clk_uart_prev_q <= 1'b0;
    end else begin
      rx_meta_q       <= rx;
      rx_s_q          <= rx_meta_q;
      rx_prev_q       <= rx_s_q;
      clk_uart_prev_q <= clk_uart;
    end
  end

  assign rx_fall       = rx_prev_q & ~rx_s_q;
  assign uart_tick     = clk_uart & ~clk_uart_prev_q;
  assign last_data_bit = (bit_cnt_q == (cfg_size_q ? 3'd7 : 3'd6));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Only the start-bit detection and the single-cycle
  // DONE state advance without a bit-centre tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_fall) state_d = START;
      START:   if (uart_tick) state_d = rx_s_q ? IDLE : DATA;
      DATA:    if (uart_tick && last_data_bit) state_d = cfg_par_en_q ? PARITY : STOP;
      PARITY:  if (uart_tick) state_d = STOP;
      STOP:    if (uart_tick && (stop_cnt_q == cfg_stop_q)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    cfg_size_d     = cfg_size_q;
    cfg_par_en_d   = cfg_par_en_q;
    cfg_par_mode_d = cfg_par_mode_q;
    cfg_stop_d     = cfg_stop_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    stop_cnt_d     = stop_cnt_q;
    par_err_acc_d  = par_err_acc_q;
    frm_err_acc_d  = frm_err_acc_q;
    data_d         = data_q;
    valid_d        = 1'b0;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;
    uart_enable    = (state_q != IDLE);
    ready          = (state_q == IDLE);

    case (state_q)
      IDLE: begin
        // The frame format is frozen here for the whole frame.
        if (rx_fall) begin
          cfg_size_d     = data_size;
          cfg_par_en_d   = parity_en;
          cfg_par_mode_d = parity_mode;
          cfg_stop_d     = stop_bit_size;
          bit_cnt_d      = 3'd0;
          stop_cnt_d     = 1'b0;
          par_err_acc_d  = 1'b0;
          frm_err_acc_d  = 1'b0;
        end
      end
      DATA: begin
        // On the 7th bit of a 7-bit frame the extra right shift leaves the
        // character right-aligned with a zero MSB, so parity and the output
        // load can use shift_q directly.
        if (uart_tick) begin
          if (last_data_bit && !cfg_size_q) begin
            shift_d = {1'b0, rx_s_q, shift_q[7:2]};
          end else begin
            shift_d = {rx_s_q, shift_q[7:1]};
          end
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      PARITY: begin
        if (uart_tick) begin
          par_err_acc_d = rx_s_q ^ (cfg_par_mode_q[0] ^ (cfg_par_mode_q[1] & (^shift_q)));
        end
      end
      STOP: begin
        if (uart_tick) begin
          if (!rx_s_q) begin
            frm_err_acc_d = 1'b1;
          end
          stop_cnt_d = 1'b1;
        end
      end
      DONE: begin
        data_d         = shift_q;
        parity_error_d = par_err_acc_q;
        frame_error_d  = frm_err_acc_q;
        valid_d        = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_size_q     <= 1'b0;
      cfg_par_en_q   <= 1'b0;
      cfg_par_mode_q <= 2'b00;
      cfg_stop_q     <= 1'b0;
      shift_q        <= 8'h00;
      bit_cnt_q      <= 3'd0;
      stop_cnt_q     <= 1'b0;
      par_err_acc_q  <= 1'b0;
      frm_err_acc_q  <= 1'b0;
      data_q         <= 8'h00;
      valid_q        <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      cfg_size_q     <= cfg_size_d;
      cfg_par_en_q   <= cfg_par_en_d;
      cfg_par_mode_q <= cfg_par_mode_d;
      cfg_stop_q     <= cfg_stop_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      stop_cnt_q     <= stop_cnt_d;
      par_err_acc_q  <= par_err_acc_d;
      frm_err_acc_q  <= frm_err_acc_d;
      data_q         <= data_d;
      valid_q        <= valid_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
    end
  end

  assign data         = data_q;
  assign valid        = valid_q;
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. A generator model answers
// uart_enable with a 16-clk/bit clk_uart; frames are driven bit by bit on rx
// and a frame-level model predicts data and error flags for each frame.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       clk_uart = 1'b0;
  logic       uart_enable;
  logic       data_size;
  logic       parity_en;
  logic [1:0] parity_mode;
  logic       stop_bit_size;
  logic [7:0] data;
  logic       valid;
  logic       parity_error;
  logic       frame_error;
  logic       ready;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  frame_t     exp_q[$];
  int         n_compared = 0;
  int         n_mismatched = 0;
  int         valid_count = 0;
  int         gen_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_perr = 1'b0;
  logic       last_ferr = 1'b0;
  logic       prev_valid = 1'b0;
  int         base;

  uart_rx dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .clk_uart(clk_uart),
    .uart_enable(uart_enable),
    .data_size(data_size),
    .parity_en(parity_en),
    .parity_mode(parity_mode),
    .stop_bit_size(stop_bit_size),
    .data(data),
    .valid(valid),
    .parity_error(parity_error),
    .frame_error(frame_error),
    .ready(ready)
  );

  // 10-unit system clock.
  always #5 clk = ~clk;

  // Bit clock generator: held low while disabled, then a 16-clk square wave
  // starting low, so the first rising edge lands half a bit after enable.
  always @(posedge clk) begin
    if (!uart_enable) begin
      gen_cnt  <= 0;
      clk_uart <= 1'b0;
    end else begin
      gen_cnt  <= gen_cnt + 1;
      clk_uart <= (((gen_cnt + 1) / 8) % 2) == 1;
    end
  end

  // One comparison: counts it and reports a failure line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, actual, expected, $time);
    end
  endtask

  // Frame-level expectation worked out from the line format: parity by
  // counting ones, frame error if any stop bit is low.
  function automatic frame_t modelFrame(input logic [7:0] ch, input bit eight, input bit pen,
                                        input logic [1:0] mode, input logic pbit,
                                        input logic s0, input logic s1, input bit two_stop);
    frame_t f;
    int ones;
    f.data = eight ? ch : {1'b0, ch[6:0]};
    ones = $countones(f.data) + int'(pbit);
    f.perr = 1'b0;
    if (pen) begin
      case (mode)
        2'b11:   f.perr = (ones % 2) != 1;
        2'b10:   f.perr = (ones % 2) != 0;
        2'b01:   f.perr = (pbit != 1'b1);
        default: f.perr = (pbit != 1'b0);
      endcase
    end
    f.ferr = !s0 || (two_stop && !s1);
    return f;
  endfunction

  // Drives one frame on rx using the current configuration inputs, queueing
  // its expectation first. Optional hooks: start-latency check, forcing
  // parity_mode to space during data bit 2, and a reset in a data bit.
  task automatic applyStimulus(input logic [7:0] ch, input logic par_bit, input logic stop0,
                               input logic stop1, input bit chk_latency, input bit toggle_mode,
                               input int abort_bit);
    logic bits[$];
    bit eight, pen, two;
    logic [1:0] mode;
    eight = data_size;
    pen   = parity_en;
    two   = stop_bit_size;
    mode  = parity_mode;
    exp_q.push_back(modelFrame(ch, eight, pen, mode, par_bit, stop0, stop1, two));
    bits.push_back(1'b0);
    for (int i = 0; i < (eight ? 8 : 7); i++) bits.push_back(ch[i]);
    if (pen) bits.push_back(par_bit);
    bits.push_back(stop0);
    if (two) bits.push_back(stop1);
    for (int b = 0; b < bits.size(); b++) begin
      rx = bits[b];
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        if (chk_latency && b == 0 && k == 2) checkOutput("start_lat_pre", 32'(uart_enable), 0);
        if (chk_latency && b == 0 && k == 3) checkOutput("start_lat_en", 32'(uart_enable), 1);
        if (toggle_mode && b == 3 && k == 1) parity_mode = 2'b00;
        if (abort_bit >= 0 && b == abort_bit + 1 && k == 8) begin
          #2 rst = 1'b1;
          #1;
          checkOutput("abort_data", 32'(data), 0);
          checkOutput("abort_valid", 32'(valid), 0);
          checkOutput("abort_perr", 32'(parity_error), 0);
          checkOutput("abort_ferr", 32'(frame_error), 0);
          checkOutput("abort_enable", 32'(uart_enable), 0);
          checkOutput("abort_ready", 32'(ready), 1);
          return;
        end
      end
    end
  endtask

  // Compare process: every valid pulse must match the next queued frame and
  // last only one cycle; between pulses the outputs must hold.
  always @(negedge clk) begin : compare_proc
    frame_t f;
    if (rst) begin
      exp_q.delete();
      last_data  <= 8'h00;
      last_perr  <= 1'b0;
      last_ferr  <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      if (valid) begin
        valid_count <= valid_count + 1;
        checkOutput("valid_width", 32'(prev_valid), 0);
        checkOutput("valid_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          f = exp_q.pop_front();
          checkOutput("frame_data", 32'(data), 32'(f.data));
          checkOutput("frame_perr", 32'(parity_error), 32'(f.perr));
          checkOutput("frame_ferr", 32'(frame_error), 32'(f.ferr));
          last_data <= f.data;
          last_perr <= f.perr;
          last_ferr <= f.ferr;
        end
      end else begin
        checkOutput("hold_data", 32'(data), 32'(last_data));
        checkOutput("hold_perr", 32'(parity_error), 32'(last_perr));
        checkOutput("hold_ferr", 32'(frame_error), 32'(last_ferr));
      end
      prev_valid <= valid;
    end
  end

  // Safety net in case the run ever stalls.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    rst = 1'b1;
    rx = 1'b1;
    data_size = 1'b1;
    parity_en = 1'b0;
    parity_mode = 2'b00;
    stop_bit_size = 1'b0;
    #1;
    checkOutput("rst_data", 32'(data), 0);
    checkOutput("rst_valid", 32'(valid), 0);
    checkOutput("rst_perr", 32'(parity_error), 0);
    checkOutput("rst_ferr", 32'(frame_error), 0);
    checkOutput("rst_enable", 32'(uart_enable), 0);
    checkOutput("rst_ready", 32'(ready), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] 8N1 0xA5");
    applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    checkOutput("a5_count", 32'(valid_count), 1);
    checkOutput("a5_data", 32'(data), 'hA5);
    checkOutput("a5_perr", 32'(parity_error), 0);
    checkOutput("a5_ferr", 32'(frame_error), 0);
    checkOutput("a5_enable", 32'(uart_enable), 0);
    checkOutput("a5_ready", 32'(ready), 1);
    repeat (20) @(negedge clk);

    $display("[TB] 7E2 0x53 back-to-back, second with bad parity");
    data_size = 1'b0;
    parity_en = 1'b1;
    parity_mode = 2'b10;
    stop_bit_size = 1'b1;
    repeat (5) @(negedge clk);
    base = valid_count;
    applyStimulus(8'h53, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    checkOutput("e2a_data", 32'(data), 'h53);
    checkOutput("e2a_perr", 32'(parity_error), 0);
    applyStimulus(8'h53, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    checkOutput("e2b_data", 32'(data), 'h53);
    checkOutput("e2b_perr", 32'(parity_error), 1);
    checkOutput("e2b_ferr", 32'(frame_error), 0);
    checkOutput("e2_count", 32'(valid_count - base), 2);
    repeat (20) @(negedge clk);

    $display("[TB] 8O1 0x00 with low stop bit, then break");
    data_size = 1'b1;
    parity_mode = 2'b11;
    stop_bit_size = 1'b0;
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    checkOutput("o1_ferr", 32'(frame_error), 1);
    checkOutput("o1_data", 32'(data), 'h00);
    checkOutput("o1_perr", 32'(parity_error), 0);
    base = valid_count;
    repeat (48) @(negedge clk);
    checkOutput("break_count", 32'(valid_count - base), 0);
    checkOutput("break_enable", 32'(uart_enable), 0);
    rx = 1'b1;
    repeat (16) @(negedge clk);
    applyStimulus(8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    checkOutput("post_break_data", 32'(data), 'h81);
    checkOutput("post_break_ferr", 32'(frame_error), 0);
    checkOutput("post_break_count", 32'(valid_count - base), 1);
    repeat (20) @(negedge clk);

    $display("[TB] glitch on rx");
    parity_en = 1'b0;
    parity_mode = 2'b00;
    repeat (16) @(negedge clk);
    base = valid_count;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("glitch_enable_on", 32'(uart_enable), 1);
    checkOutput("glitch_ready_off", 32'(ready), 0);
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (24) @(negedge clk);
    checkOutput("glitch_enable_off", 32'(uart_enable), 0);
    checkOutput("glitch_ready_on", 32'(ready), 1);
    checkOutput("glitch_count", 32'(valid_count - base), 0);
    repeat (10) @(negedge clk);

    $display("[TB] mark/space parity and mid-frame mode change");
    parity_en = 1'b1;
    parity_mode = 2'b01;
    applyStimulus(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    checkOutput("mark_perr", 32'(parity_error), 0);
    checkOutput("mark_data", 32'(data), 'h01);
    parity_mode = 2'b00;
    applyStimulus(8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    checkOutput("space_perr", 32'(parity_error), 0);
    parity_mode = 2'b10;
    applyStimulus(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    checkOutput("toggle_perr", 32'(parity_error), 0);
    checkOutput("toggle_data", 32'(data), 'h01);
    repeat (20) @(negedge clk);

    $display("[TB] reset during data bit 4, then 0x3C");
    parity_en = 1'b0;
    parity_mode = 2'b00;
    base = valid_count;
    applyStimulus(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("abort_count", 32'(valid_count - base), 0);
    applyStimulus(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    checkOutput("after_rst_data", 32'(data), 'h3C);
    checkOutput("after_rst_count", 32'(valid_count - base), 1);
    repeat (20) @(negedge clk);

    checkOutput("frames_left", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
